// File: rtl/aer_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : aer_arbiter_rr
// Brief    : N-channel AER up/down event arbiter. Captures asynchronous
//            up/down spike edges per channel and serves them round-robin
//            over a go / fs_sen / fe_d transmit handshake. Lost events
//            are counted in a saturating drop counter.
// Options  : AER_TIMEOUT_EN - adds a handshake timeout that abandons a
//            stalled grant and pulses err.
// Revision : 1.0 - initial release
// ============================================================================
module aer_arbiter_rr #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 1,
  parameter int DROP_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] up_in,
  input  logic [NUM_CH-1:0] down_in,
  input  logic              fs_sen,
  input  logic              fe_d,
  output logic              go,
  output logic [ADDR_W-1:0] ch_addr,
  output logic [NUM_CH-1:0] ch_onehot,
  output logic              up,
  output logic              down,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              err
);

  localparam int c_NUM_SLOTS = 2 * NUM_CH;
  localparam int c_SLOT_W    = $clog2(c_NUM_SLOTS);
  localparam int c_CH_W      = c_SLOT_W - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [c_NUM_SLOTS-1:0] w_raw;
  logic [c_NUM_SLOTS-1:0] r_sync1;
  logic [c_NUM_SLOTS-1:0] r_sync2;
  logic [c_NUM_SLOTS-1:0] r_edge;
  logic [c_NUM_SLOTS-1:0] r_pend;
  logic [c_NUM_SLOTS-1:0] w_rise;
  logic [c_NUM_SLOTS-1:0] w_clr;
  logic [1:0]             r_settle;
  logic                   w_drop;
  logic                   w_found;
  logic [c_SLOT_W-1:0]    w_win;
  logic [c_CH_W-1:0]      w_win_ch;
  logic [c_SLOT_W-1:0]    r_win;
  logic [c_SLOT_W-1:0]    r_rr_ptr;
  logic [c_SLOT_W-1:0]    w_rr_next;
  logic                   w_timeout;
  logic                   r_go;
  logic [ADDR_W-1:0]      r_ch_addr;
  logic [NUM_CH-1:0]      r_ch_onehot;
  logic                   r_up;
  logic                   r_down;
  logic                   r_busy;
  logic [DROP_W-1:0]      r_drop_cnt;

  // Slot 2*ch is the channel's up event, slot 2*ch+1 its down event.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    assign w_raw[2*i]   = up_in[i];
    assign w_raw[2*i+1] = down_in[i];
  end

  // Two-flop synchroniser, edge register and post-reset settle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_edge   <= '0;
      r_settle <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
    end
  end

  // Rises are ignored until the edge register has seen the synchronised
  // level once after reset, so inputs held high through reset are silent.
  assign w_rise = (r_sync2 & ~r_edge) & {c_NUM_SLOTS{r_settle == 2'd3}};

  // The winner's pending bit is consumed on transmitter start or timeout.
  always_comb begin
    w_clr = '0;
    if (r_state == S_GRANT && (fs_sen || w_timeout)) w_clr[r_win] = 1'b1;
  end

  // A rise that coincides with the clear of its slot re-arms it, not a drop.
  assign w_drop = |(w_rise & r_pend & ~w_clr);

  // Pending slots and saturating drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend     <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_rise;
      if (w_drop && (r_drop_cnt != {DROP_W{1'b1}})) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
    end
  end

  // Round-robin search: first pending slot at or above rr_ptr, wrapping.
  always_comb begin
    logic [c_SLOT_W:0] v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = '0;
    for (int k = 0; k < c_NUM_SLOTS; k++) begin
      v_idx = {1'b0, r_rr_ptr} + (c_SLOT_W+1)'(k);
      if (v_idx >= (c_SLOT_W+1)'(c_NUM_SLOTS)) v_idx = v_idx - (c_SLOT_W+1)'(c_NUM_SLOTS);
      if (!w_found && r_pend[v_idx[c_SLOT_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = v_idx[c_SLOT_W-1:0];
      end
    end
  end

  assign w_win_ch  = w_win[c_SLOT_W-1:1];
  assign w_rr_next = (r_win == c_SLOT_W'(c_NUM_SLOTS - 1)) ? '0 : r_win + c_SLOT_W'(1);

`ifdef AER_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYC);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_err;
  logic              w_leave;

  // Handshake progress takes priority over an expiring timeout.
  assign w_timeout = (r_to_cnt == c_TO_W'(TIMEOUT_CYC - 1)) &&
                     ((r_state == S_GRANT && !fs_sen) || (r_state == S_BUSY && !fe_d));

  // Flags a state change this cycle, used to restart the timeout counter.
  always_comb begin
    case (r_state)
      S_IDLE:  w_leave = w_found;
      S_GRANT: w_leave = fs_sen || w_timeout;
      S_BUSY:  w_leave = fe_d || w_timeout;
      default: w_leave = !fs_sen && !fe_d;
    endcase
  end

  // Timeout counter runs only in GRANT/BUSY and restarts on every transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_leave || !(r_state == S_GRANT || r_state == S_BUSY)) r_to_cnt <= '0;
      else                                                       r_to_cnt <= r_to_cnt + c_TO_W'(1);
    end
  end

  assign err = r_err;
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign err              = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYC != 0);
`endif

  // Handshake FSM with registered outputs latched from the winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_win       <= '0;
      r_rr_ptr    <= '0;
      r_go        <= 1'b0;
      r_ch_addr   <= '0;
      r_ch_onehot <= '0;
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state     <= S_GRANT;
            r_win       <= w_win;
            r_go        <= 1'b1;
            r_busy      <= 1'b1;
            r_ch_addr   <= ADDR_W'(w_win_ch);
            r_ch_onehot <= NUM_CH'(1) << w_win_ch;
            r_up        <= ~w_win[0];
            r_down      <= w_win[0];
          end
        end
        S_GRANT: begin
          if (fs_sen) begin
            r_state  <= S_BUSY;
            r_rr_ptr <= w_rr_next;
          end else if (w_timeout) begin
            r_state     <= S_DONE;
            r_rr_ptr    <= w_rr_next;
            r_go        <= 1'b0;
            r_ch_onehot <= '0;
            r_up        <= 1'b0;
            r_down      <= 1'b0;
          end
        end
        S_BUSY: begin
          if (fe_d || w_timeout) begin
            r_state     <= S_DONE;
            r_go        <= 1'b0;
            r_ch_onehot <= '0;
            r_up        <= 1'b0;
            r_down      <= 1'b0;
          end
        end
        default: begin
          if (!fs_sen && !fe_d) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign go        = r_go;
  assign ch_addr   = r_ch_addr;
  assign ch_onehot = r_ch_onehot;
  assign up        = r_up;
  assign down      = r_down;
  assign busy      = r_busy;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_aer_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_aer_arbiter_rr
// Brief    : Directed self-checking bench for aer_arbiter_rr. A 2-channel
//            instance covers latency, ordering and reset; a 4-channel
//            instance with a 2-bit drop counter covers drops, saturation
//            and (with AER_TIMEOUT_EN) the handshake timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aer_arbiter_rr;

  logic       clk = 1'b0;
  logic       reset;

  logic [1:0] up_in2, down_in2;
  logic       fs_sen2, fe_d2;
  logic       go2, up2, down2, busy2, err2;
  logic [0:0] ch_addr2;
  logic [1:0] ch_onehot2;
  logic [7:0] drop_cnt2;

  logic [3:0] up_in4, down_in4;
  logic       fs_sen4, fe_d4;
  logic       go4, up4, down4, busy4, err4;
  logic [1:0] ch_addr4;
  logic [3:0] ch_onehot4;
  logic [1:0] drop_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aer_arbiter_rr #(.NUM_CH(2), .ADDR_W(1), .DROP_W(8), .TIMEOUT_CYC(1024)) u_dut2 (
    .clk(clk), .reset(reset), .up_in(up_in2), .down_in(down_in2),
    .fs_sen(fs_sen2), .fe_d(fe_d2), .go(go2), .ch_addr(ch_addr2),
    .ch_onehot(ch_onehot2), .up(up2), .down(down2), .busy(busy2),
    .drop_cnt(drop_cnt2), .err(err2)
  );

  aer_arbiter_rr #(.NUM_CH(4), .ADDR_W(2), .DROP_W(2), .TIMEOUT_CYC(16)) u_dut4 (
    .clk(clk), .reset(reset), .up_in(up_in4), .down_in(down_in4),
    .fs_sen(fs_sen4), .fe_d(fe_d4), .go(go4), .ch_addr(ch_addr4),
    .ch_onehot(ch_onehot4), .up(up4), .down(down4), .busy(busy4),
    .drop_cnt(drop_cnt4), .err(err4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] f_go(input bit d);
    return d ? 32'(go4) : 32'(go2);
  endfunction
  function automatic logic [31:0] f_addr(input bit d);
    return d ? 32'(ch_addr4) : 32'(ch_addr2);
  endfunction
  function automatic logic [31:0] f_oh(input bit d);
    return d ? 32'(ch_onehot4) : 32'(ch_onehot2);
  endfunction
  function automatic logic [31:0] f_up(input bit d);
    return d ? 32'(up4) : 32'(up2);
  endfunction
  function automatic logic [31:0] f_dn(input bit d);
    return d ? 32'(down4) : 32'(down2);
  endfunction
  function automatic logic [31:0] f_busy(input bit d);
    return d ? 32'(busy4) : 32'(busy2);
  endfunction

  task automatic set_fs(input bit d, input logic v);
    if (d) fs_sen4 = v; else fs_sen2 = v;
  endtask
  task automatic set_fe(input bit d, input logic v);
    if (d) fe_d4 = v; else fe_d2 = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
  endtask

  // Bounded wait for go; an expired bound shows up as a failed check.
  task automatic wait_go(input bit d);
    int n;
    n = 0;
    while (f_go(d) != 32'd1 && n < 30) begin
      tick();
      n++;
    end
    check("go_wait", f_go(d), 32'd1);
  endtask

  // Transmitter: start pulse, then frame-end pulse, then back to idle.
  task automatic handshake(input bit d);
    set_fs(d, 1'b1);
    tick();
    set_fs(d, 1'b0);
    check("hs_go_busy", f_go(d), 32'd1);
    set_fe(d, 1'b1);
    tick();
    check("hs_go_low", f_go(d), 32'd0);
    check("hs_pol_low", f_up(d) | f_dn(d), 32'd0);
    set_fe(d, 1'b0);
    tick();
    check("hs_idle", f_busy(d), 32'd0);
  endtask

  task automatic serve(input bit d, input int addr, input bit dn);
    wait_go(d);
    check("srv_addr", f_addr(d), 32'(addr));
    check("srv_onehot", f_oh(d), 32'd1 << addr);
    check("srv_up", f_up(d), 32'(!dn));
    check("srv_down", f_dn(d), 32'(dn));
    handshake(d);
  endtask

  task automatic pulse4(input bit dn, input logic [1:0] ch);
    if (dn) down_in4[ch] = 1'b1; else up_in4[ch] = 1'b1;
    repeat (3) tick();
    if (dn) down_in4[ch] = 1'b0; else up_in4[ch] = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1;
    up_in2 = '0; down_in2 = '0; fs_sen2 = 1'b0; fe_d2 = 1'b0;
    up_in4 = '0; down_in4 = '0; fs_sen4 = 1'b0; fe_d4 = 1'b0;
    repeat (3) tick();
    check("rst_go", go2, 0);
    check("rst_busy", busy2, 0);
    check("rst_onehot", ch_onehot2, 0);
    check("rst_addr", ch_addr2, 0);
    check("rst_drop", drop_cnt2, 0);
    check("rst_err", err4, 0);
    do_reset();

    // Single up event on channel 1: go on the 4th clock.
    up_in2 = 2'b10;
    repeat (3) tick();
    check("lat_go_early", go2, 0);
    tick();
    check("lat_go", go2, 1);
    check("lat_addr", ch_addr2, 1);
    check("lat_onehot", ch_onehot2, 2'b10);
    check("lat_up", up2, 1);
    check("lat_down", down2, 0);
    up_in2 = 2'b00;
    repeat (2) tick();
    check("lat_hold_go", go2, 1);
    handshake(0);

    // All four slots at once: served 0,1,2,3, then pointer wraps to 0.
    do_reset();
    up_in2 = 2'b11;
    down_in2 = 2'b11;
    serve(0, 0, 0);
    serve(0, 0, 1);
    serve(0, 1, 0);
    serve(0, 1, 1);
    check("all4_drop", drop_cnt2, 0);
    up_in2 = 2'b00;
    down_in2 = 2'b00;
    repeat (4) tick();
    down_in2 = 2'b11;
    serve(0, 0, 1);
    serve(0, 1, 1);
    down_in2 = 2'b00;

    // Repeated down events on ch2 while its grant is stalled.
    pulse4(1, 2'd2);
    check("drp_go", go4, 1);
    check("drp_addr", ch_addr4, 2);
    check("drp_onehot", ch_onehot4, 4'b0100);
    check("drp_down", down4, 1);
    check("drp_up", up4, 0);
    check("drp_cnt0", drop_cnt4, 0);
    pulse4(1, 2'd2);
    pulse4(1, 2'd2);
    check("drp_cnt2", drop_cnt4, 2);
    check("drp_addr_stable", ch_addr4, 2);
    fs_sen4 = 1'b1;
    tick();
    fs_sen4 = 1'b0;
    pulse4(1, 2'd2);
    check("drp_after_clr", drop_cnt4, 2);
    check("drp_busy_go", go4, 1);
    fe_d4 = 1'b1;
    tick();
    fe_d4 = 1'b0;
    tick();
    check("drp_go_low", go4, 0);
    serve(1, 2, 1);
    check("drp_final", drop_cnt4, 2);
    check("drp_err", err4, 0);

    // Saturation of the 2-bit drop counter.
    do_reset();
    pulse4(0, 2'd0);
    check("sat_go", go4, 1);
    check("sat_addr", ch_addr4, 0);
    check("sat_up", up4, 1);
    repeat (3) pulse4(0, 2'd0);
    check("sat_3", drop_cnt4, 3);
    repeat (2) pulse4(0, 2'd0);
    check("sat_hold", drop_cnt4, 3);

    // Asynchronous reset mid-handshake, inputs held high through it.
    up_in2 = 2'b10;
    up_in4 = 4'b0001;
    wait_go(0);
    fs_sen2 = 1'b1;
    tick();
    fs_sen2 = 1'b0;
    check("ar_go_pre", go2, 1);
    check("ar_up_pre", up2, 1);
    #2 reset = 1'b1;
    #1;
    check("ar_go", go2, 0);
    check("ar_up", up2, 0);
    check("ar_onehot", ch_onehot2, 0);
    check("ar_busy", busy2, 0);
    check("ar_drop", drop_cnt4, 0);
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check("ar_nogrant2", go2, 0);
    check("ar_nobusy2", busy2, 0);
    check("ar_nogrant4", go4, 0);
    up_in2 = 2'b00;
    up_in4 = 4'b0000;

`ifdef AER_TIMEOUT_EN
    // Stalled grant times out after 16 clocks; next slot is served.
    do_reset();
    up_in4 = 4'b0010;
    down_in4 = 4'b1000;
    wait_go(1);
    check("to_addr", ch_addr4, 1);
    check("to_up", up4, 1);
    repeat (15) tick();
    check("to_err_early", err4, 0);
    check("to_go_early", go4, 1);
    tick();
    check("to_err", err4, 1);
    check("to_go_low", go4, 0);
    tick();
    check("to_err_pulse", err4, 0);
    serve(1, 3, 1);
    check("to_drop", drop_cnt4, 0);
    up_in4 = 4'b0000;
    down_in4 = 4'b0000;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aer_arbiter_rr.md
Name: aer_arbiter_rr

Overview:
- Parametrised N-channel successor to the two-channel AER up/down arbiter.
- Captures up/down spike events from NUM_CH channels and arbitrates them round-robin onto a single AER transmit handshake (go / fs_sen / fe_d).
- Outputs a binary channel address plus a one-hot channel vector, with polarity flags.
- Counts events that are lost because a slot is already pending.

Parameters:
- NUM_CH, 2, number of event channels (2..16).
- ADDR_W, 1, width of ch_addr; must be >= clog2(NUM_CH).
- DROP_W, 8, width of the saturating dropped-event counter.
- TIMEOUT_CYC, 1024, handshake timeout in clocks; used only with AER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- up_in  in  NUM_CH  per-channel up-event request; asynchronous level; the event is its rising edge.
- down_in  in  NUM_CH  per-channel down-event request; asynchronous level; the event is its rising edge.
- fs_sen  in  1  transmitter has started sending the granted event.
- fe_d  in  1  transmitter has finished the frame.
- go  out  1  event valid; request to transmitter.
- ch_addr  out  ADDR_W  binary index of the granted channel.
- ch_onehot  out  NUM_CH  one-hot granted channel.
- up  out  1  granted event is an up event.
- down  out  1  granted event is a down event.
- busy  out  1  FSM is not in IDLE.
- drop_cnt  out  DROP_W  saturating count of dropped events.
- err  out  1  one-cycle pulse on handshake timeout; tied 0 without AER_TIMEOUT_EN.

Behaviour:
- Input capture:
  - Each of the 2*NUM_CH inputs passes through a 2-flop synchroniser and then an edge register.
  - A rise sets that slot's pending bit on the following clock.
  - Slot index = 2*ch + pol, with pol 0 = up and pol 1 = down.
- Latency: from the first rising clk at which an input is high, with the FSM in IDLE and nothing else pending, go rises on the 4th rising clk.
- Drop: a rise on a slot whose pending bit is already set increments drop_cnt, which saturates at all-ones. Several simultaneous drops in one cycle add 1 only.
- FSM states are IDLE, GRANT, BUSY, DONE:
  - IDLE: if any slot is pending, register the winner and go to GRANT.
    - Winner is the first pending slot at or above rr_ptr, wrapping modulo 2*NUM_CH.
  - GRANT: go=1; ch_addr, ch_onehot, up and down are driven from the latched winner and held stable.
    - On fs_sen=1: clear the winner's pending bit, set rr_ptr = winner+1 (wrapping 2*NUM_CH-1 -> 0), go to BUSY.
  - BUSY: go=1 and outputs held. On fe_d=1: go to DONE.
  - DONE: go=0 and up/down/ch_onehot=0; ch_addr holds its last value. When fs_sen=0 and fe_d=0, go to IDLE.
- Arbitration rules:
  - A winner change is never visible while go=1.
  - New edges arriving during GRANT/BUSY/DONE only set pending bits.
  - If a set and a clear of the same slot occur in the same cycle, the set wins and the event is re-served later.
  - Simultaneous up and down on one channel produce two pending slots; up is served first only if rr_ptr ordering reaches it first.
  - up and down are never both 1.
- Reset values, applied immediately, including mid-handshake:
  - go, up, down, busy, err = 0; ch_addr = 0; ch_onehot = 0; drop_cnt = 0.
  - All pending bits and synchroniser/edge flops = 0; rr_ptr = 0; FSM = IDLE.
  - Inputs held high through reset deassertion do not generate events, because the edge register samples high before the pending logic sees the rise.

Optional Feature:
- Macro: AER_TIMEOUT_EN.
- Defined:
  - A counter runs in GRANT and BUSY and clears on every state change.
  - When it reaches TIMEOUT_CYC-1 the FSM goes to DONE, err pulses for 1 cycle, and the winner's pending bit is cleared; rr_ptr still advances, and the abandoned event is not counted in drop_cnt.
- Undefined: no counter is built, err is tied 0, and GRANT/BUSY wait indefinitely.

Test Plan:
- Single up_in[1] rise, NUM_CH=2, with transmitter model responding fs_sen at +2 and fe_d at +5 -> go high 4 clks after the input rise; ch_addr=1, ch_onehot=2'b10, up=1, down=0; go low after fe_d; busy returns 0 once fs_sen and fe_d are low.
- All 4 slots rise in the same cycle after reset, NUM_CH=2 -> 4 grants in order slot 0,1,2,3 (ch0 up, ch0 down, ch1 up, ch1 down); rr_ptr wraps to 0; drop_cnt=0.
- NUM_CH=4: hold fs_sen low in GRANT, pulse down_in[2] 3 times, then a 4th pulse after fs_sen -> drop_cnt=2; the slot is re-served once more after the current handshake.
- Assert reset while in BUSY with go=1 -> go, up and ch_onehot drop in the same cycle without a clock; after release with inputs held high, no grant occurs.
- DROP_W=2: 5 drops on one slot -> drop_cnt saturates at 3.
- AER_TIMEOUT_EN, TIMEOUT_CYC=16, fs_sen never asserted -> err pulse 16 clks after go rises; go falls; next pending slot is granted; drop_cnt unchanged.
